motor_speed_sequencer: RTL
==========================

Name: motor_speed_sequencer

Overview:
Control FSM for the PWM motor datapath. Converts debounced button pulses into a speed level, ramps the PWM compare value toward that level's duty, and runs an auto-off countdown timer. Feeds the PWM comparator with a glitch-free duty value, plus the LED/FND display logic with the level and remaining seconds. Runs on the system clock; uses the 1 kHz tick only as an enable.

Parameters:
PWM_PERIOD, 1000, PWM counter period in counts (counter runs 0..PWM_PERIOD-1)
MAX_LEVEL, 4, highest speed level; levels 0..MAX_LEVEL
RAMP_STEP, 25, duty change per ramp update
RAMP_MS, 20, 1 kHz ticks between ramp updates
TIMER_STEP_S, 10, seconds added per timer button press
TIMER_MAX_S, 30, timer preset ceiling; next press wraps to 0 (off)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_tick_1khz  in  1  one-cycle enable pulse at 1 kHz
i_period_end  in  1  one-cycle pulse when the PWM counter wraps to 0
i_btn_up  in  1  debounced one-cycle pulse: level +1
i_btn_down  in  1  debounced one-cycle pulse: level -1
i_btn_stop  in  1  debounced one-cycle pulse: ramp to stop
i_btn_timer  in  1  debounced one-cycle pulse: step timer preset
o_duty  out  10  PWM compare value (pwm = counter < o_duty)
o_speed_state  out  3  current target level
o_remaining_s  out  6  timer seconds remaining (0 = timer off)
o_busy  out  1  high when state is not IDLE

Behaviour:
- Reset (i_reset low, async): state IDLE; level, internal duty, o_duty, o_remaining_s, ms/ramp counters all 0; o_speed_state 0; o_busy 0. Asserting reset mid-ramp forces outputs to 0 immediately.
- Target duty = level * (PWM_PERIOD / MAX_LEVEL); at MAX_LEVEL it equals PWM_PERIOD (always on).
- Button priority per cycle: stop > up/down > timer. Up and down in the same cycle cancel each other (no change). Up at MAX_LEVEL saturates; down at 0 does nothing.
- States:
  - IDLE: level 0, duty 0. Up -> level 1, go to RAMP. Down, stop and timer are ignored.
  - RAMP: every RAMP_MS ticks, duty moves toward the target by RAMP_STEP, clamped at the target with no overshoot. When duty equals the target, go to RUN. Up/down retarget without restarting the ramp counter. If the level becomes 0, go to BRAKE.
  - RUN: up/down -> RAMP. Down to level 0 -> BRAKE.
  - BRAKE: level forced to 0. Duty ramps down as in RAMP. Up/down ignored. Duty reaching 0 -> IDLE. Up in the same cycle as reaching 0 is ignored.
  - Stop in any non-IDLE state -> BRAKE and clears the timer.
- Shadow update: the internal duty is copied to o_duty only on i_period_end, so there is no mid-period glitch. Latency from duty change to o_duty is at most one PWM period.
- Timer:
  - Press in RAMP or RUN steps o_remaining_s by TIMER_STEP_S through 0, 10, 20, 30, 0. Ignored in IDLE and BRAKE.
  - While nonzero, a ms counter counts 1 kHz ticks 0..999; at 999 o_remaining_s decrements.
  - Transition 1 -> 0 forces BRAKE. A new preset resets the ms counter to 0.
- Tick and button in the same cycle: both take effect.

Optional Feature:
KICKSTART_EN: when defined, leaving IDLE sets the internal duty to PWM_PERIOD for 50 ticks (kick), then ramps toward the target in RAMP; o_speed_state is unaffected. Stop during the kick goes to BRAKE immediately. Without the macro, leaving IDLE starts the ramp from duty 0.

Test Plan:
- Reset held low with buttons toggling -> o_duty 0, o_speed_state 0, o_remaining_s 0, o_busy 0. Release, press up -> o_speed_state 1, o_busy 1; o_duty steps 25, 50, ... every 20 ticks at period ends and holds at 250; state RUN.
- Five up presses from IDLE -> o_speed_state saturates at 4; o_duty settles at 1000. Up and down pulsed in the same cycle -> no change.
- At level 4 in RUN, press stop -> o_speed_state 0; o_duty ramps 1000 -> 0 in 40 ramp steps; then IDLE, o_busy 0. A timer press during BRAKE is ignored.
- Level 2 RUN, two timer presses -> o_remaining_s 20. After 20000 ticks -> 0 and BRAKE starts. Third and fourth presses -> 30 then 0.
- Change internal duty mid-PWM-period with i_period_end held low -> o_duty unchanged until the next i_period_end pulse.
- With KICKSTART_EN defined, up from IDLE -> o_duty 1000 for 50 ticks, then ramps down to 250. Without the macro -> o_duty starts ramping up from 0.

Source files
------------

// File: rtl/motor_speed_sequencer.sv
// motor_speed_sequencer: button-driven speed level, duty ramp and auto-off timer.
// Optional KICKSTART_EN: full duty for 50 ticks when leaving IDLE.
module motor_speed_sequencer #(
  parameter int PWM_PERIOD   = 1000,
  parameter int MAX_LEVEL    = 4,
  parameter int RAMP_STEP    = 25,
  parameter int RAMP_MS      = 20,
  parameter int TIMER_STEP_S = 10,
  parameter int TIMER_MAX_S  = 30
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_1khz,
  input  logic       i_period_end,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_stop,
  input  logic       i_btn_timer,
  output logic [9:0] o_duty,
  output logic [2:0] o_speed_state,
  output logic [5:0] o_remaining_s,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, RAMP, RUN, BRAKE} state_t;

  localparam logic [9:0] PERIOD    = 10'(PWM_PERIOD);
  localparam logic [9:0] LVL_DUTY  = 10'(PWM_PERIOD / MAX_LEVEL);
  localparam logic [9:0] STEP      = 10'(RAMP_STEP);
  localparam logic [9:0] MS_LAST   = 10'd999;
  localparam logic [4:0] RAMP_LAST = 5'(RAMP_MS - 1);
  localparam logic [2:0] LMAX      = 3'(MAX_LEVEL);
  localparam logic [5:0] T_STEP    = 6'(TIMER_STEP_S);
  localparam logic [5:0] T_WRAP    = 6'(TIMER_MAX_S - TIMER_STEP_S);

  state_t     st, st_n;
  logic [2:0] level, level_n;
  logic [9:0] duty, duty_n;
  logic [5:0] rem, rem_n;
  logic [9:0] ms, ms_n;
  logic [4:0] rcnt, rcnt_n;
  logic       stop, inc, dec, tmr;
  logic       kicking, ramping, fire;
  logic       preset, timeout, settle;

`ifdef KICKSTART_EN
  localparam logic [5:0] KICK_TICKS = 6'd50;
  logic [5:0] kick, kick_n;
  assign kicking = (kick != '0);
`else
  assign kicking = 1'b0;
`endif

  function automatic logic [9:0] tgt_of(input logic [2:0] l);
    if (l >= LMAX) return PERIOD;
    return {7'd0, l} * LVL_DUTY;
  endfunction

  // One ramp update toward t, clamped so it never overshoots.
  function automatic logic [9:0] step_to(input logic [9:0] d,
                                         input logic [9:0] t);
    if (d < t) return (t - d > STEP) ? d + STEP : t;
    if (d > t) return (d - t > STEP) ? d - STEP : t;
    return t;
  endfunction

  assign stop    = i_btn_stop;
  assign inc     = !stop && i_btn_up && !i_btn_down;
  assign dec     = !stop && i_btn_down && !i_btn_up;
  assign tmr     = i_btn_timer && !stop && !i_btn_up && !i_btn_down;
  assign ramping = (st == RAMP || st == BRAKE) && !kicking;
  assign fire    = ramping && i_tick_1khz && (rcnt == RAMP_LAST);
  assign preset  = tmr && (st == RAMP || st == RUN);
  assign timeout = i_tick_1khz && (rem == 6'd1) && (ms == MS_LAST)
                   && !preset;

  always_comb begin
    st_n    = st;
    level_n = level;
    duty_n  = duty;
    rem_n   = rem;
    ms_n    = ms;
    rcnt_n  = rcnt;
    settle  = 1'b0;
`ifdef KICKSTART_EN
    kick_n  = kick;
    if (kicking && i_tick_1khz) kick_n = kick - 6'd1;
`endif
    if (ramping && i_tick_1khz)
      rcnt_n = (rcnt == RAMP_LAST) ? '0 : rcnt + 5'd1;
    if (fire) duty_n = step_to(duty, tgt_of(level));
    if (rem != '0 && i_tick_1khz) begin
      if (ms == MS_LAST) begin
        ms_n  = '0;
        rem_n = rem - 6'd1;
      end else begin
        ms_n  = ms + 10'd1;
      end
    end
    // A new preset restarts the second boundary.
    if (preset) begin
      rem_n = (rem > T_WRAP) ? '0 : rem + T_STEP;
      ms_n  = '0;
    end
    unique case (st)
      IDLE: begin
        if (inc) begin
          st_n    = RAMP;
          level_n = 3'd1;
          rcnt_n  = '0;
`ifdef KICKSTART_EN
          duty_n  = PERIOD;
          kick_n  = KICK_TICKS;
`else
          duty_n  = '0;
`endif
        end
      end
      RAMP, RUN: begin
        if (inc && level != LMAX) level_n = level + 3'd1;
        if (dec && level != '0) level_n = level - 3'd1;
        settle = (duty_n == tgt_of(level_n));
`ifdef KICKSTART_EN
        settle = settle && (kick_n == '0);
`endif
        if (stop || timeout || level_n == '0) begin
          st_n    = BRAKE;
          level_n = '0;
          rem_n   = '0;
          ms_n    = '0;
`ifdef KICKSTART_EN
          kick_n  = '0;
`endif
        end else if (settle) begin
          st_n   = RUN;
          rcnt_n = '0;
        end else begin
          st_n   = RAMP;
        end
      end
      BRAKE: begin
        if (duty_n == '0) begin
          st_n   = IDLE;
          rcnt_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      st     <= IDLE;
      level  <= '0;
      duty   <= '0;
      rem    <= '0;
      ms     <= '0;
      rcnt   <= '0;
      o_duty <= '0;
`ifdef KICKSTART_EN
      kick   <= '0;
`endif
    end else begin
      st    <= st_n;
      level <= level_n;
      duty  <= duty_n;
      rem   <= rem_n;
      ms    <= ms_n;
      rcnt  <= rcnt_n;
`ifdef KICKSTART_EN
      kick  <= kick_n;
`endif
      // Shadow copy only at the period wrap keeps each PWM period clean.
      if (i_period_end) o_duty <= duty;
    end
  end

  assign o_speed_state = level;
  assign o_remaining_s = rem;
  assign o_busy        = (st != IDLE);

endmodule
